id_ex_reg: RTL and testbench

ID/EX pipeline register for the five-stage CPU. It latches everything the ID stage produces: register-file read data, the sign-, zero- or LUI-extended immediate, register specifiers, PC and control. It presents these to the EX stage one cycle later. It also detects load-use hazards, inserts a bubble, and stalls PC/IF-ID. It squashes wrong-path instructions on Flush and freezes on Hold.

---
 rtl/id_ex_reg_pkg.sv | 43 ++++
 rtl/id_ex_reg_if.sv | 74 +++++++
 rtl/id_ex_reg_load_use_detect.sv | 27 ++
 rtl/id_ex_reg.sv | 128 ++++++++++++
 tb/tb_id_ex_reg.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: ALU/write-back encodings and the packed
// control bundle carried by the ID/EX, EX/MEM and MEM/WB registers.
package id_ex_reg_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd10;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'd2;

  typedef struct packed {
    logic                usesRs;
    logic                usesRt;
    logic [ALU_OP_W-1:0] aluOp;
    logic                aluSrcA;
    logic                aluSrcB;
    logic [1:0]          regDst;
    logic [1:0]          memToReg;
    logic                regWrite;
    logic                memRead;
    logic                memWrite;
  } ctrl_t;

  // A bubble carries no side effects: every control bit is cleared.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-stage fields in, registered EX-stage copies out.
interface id_ex_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  logic              Hold;
  logic              Flush;

  logic              IdValid;
  logic [DATA_W-1:0] IdPC;
  logic [DATA_W-1:0] IdRegData1;
  logic [DATA_W-1:0] IdRegData2;
  logic [DATA_W-1:0] IdExtImm;
  logic [REG_W-1:0]  IdRs;
  logic [REG_W-1:0]  IdRt;
  logic [REG_W-1:0]  IdRd;
  logic [REG_W-1:0]  IdShamt;
  logic              IdUsesRs;
  logic              IdUsesRt;
  logic [3:0]        IdALUOp;
  logic              IdALUSrcA;
  logic              IdALUSrcB;
  logic [1:0]        IdRegDst;
  logic [1:0]        IdMemToReg;
  logic              IdRegWrite;
  logic              IdMemRead;
  logic              IdMemWrite;

  logic              ExValid;
  logic [DATA_W-1:0] ExPC;
  logic [DATA_W-1:0] ExRegData1;
  logic [DATA_W-1:0] ExRegData2;
  logic [DATA_W-1:0] ExExtImm;
  logic [REG_W-1:0]  ExRs;
  logic [REG_W-1:0]  ExRt;
  logic [REG_W-1:0]  ExRd;
  logic [REG_W-1:0]  ExShamt;
  logic              ExUsesRs;
  logic              ExUsesRt;
  logic [3:0]        ExALUOp;
  logic              ExALUSrcA;
  logic              ExALUSrcB;
  logic [1:0]        ExRegDst;
  logic [1:0]        ExMemToReg;
  logic              ExRegWrite;
  logic              ExMemRead;
  logic              ExMemWrite;

  logic              Stall;
  logic [CNT_W-1:0]  BubbleCnt;

  modport master (
    output Hold, Flush, IdValid, IdPC, IdRegData1, IdRegData2, IdExtImm,
           IdRs, IdRt, IdRd, IdShamt, IdUsesRs, IdUsesRt, IdALUOp,
           IdALUSrcA, IdALUSrcB, IdRegDst, IdMemToReg, IdRegWrite,
           IdMemRead, IdMemWrite,
    input  ExValid, ExPC, ExRegData1, ExRegData2, ExExtImm, ExRs, ExRt,
           ExRd, ExShamt, ExUsesRs, ExUsesRt, ExALUOp, ExALUSrcA, ExALUSrcB,
           ExRegDst, ExMemToReg, ExRegWrite, ExMemRead, ExMemWrite,
           Stall, BubbleCnt
  );

  modport slave (
    input  Hold, Flush, IdValid, IdPC, IdRegData1, IdRegData2, IdExtImm,
           IdRs, IdRt, IdRd, IdShamt, IdUsesRs, IdUsesRt, IdALUOp,
           IdALUSrcA, IdALUSrcB, IdRegDst, IdMemToReg, IdRegWrite,
           IdMemRead, IdMemWrite,
    output ExValid, ExPC, ExRegData1, ExRegData2, ExExtImm, ExRs, ExRt,
           ExRd, ExShamt, ExUsesRs, ExUsesRt, ExALUOp, ExALUSrcA, ExALUSrcB,
           ExRegDst, ExMemToReg, ExRegWrite, ExMemRead, ExMemWrite,
           Stall, BubbleCnt
  );
endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX has not yet produced. Register 0 never creates a hazard.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             idValid,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRt,
  output logic             loadUse
);

  logic rsMatch;
  logic rtMatch;

  // Compare both ID source specifiers against the load destination.
  always_comb begin
    rsMatch = idUsesRs && (idRs == exRt);
    rtMatch = idUsesRt && (idRt == exRt);
    loadUse = idValid && exValid && exMemRead && (exRt != '0) && (rsMatch || rtMatch);
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// downstream hold and a saturating count of inserted load-use bubbles.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic  clk,
  input  logic  reset,
  id_ex_reg_if.slave bus
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    satInc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              vld_p1;
  ctrl_t             ctrl_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] rd1_p1;
  logic [DATA_W-1:0] rd2_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [REG_W-1:0]  rs_p1;
  logic [REG_W-1:0]  rt_p1;
  logic [REG_W-1:0]  rd_p1;
  logic [REG_W-1:0]  shamt_p1;
  logic [CNT_W-1:0]  bubbleCnt;

  ctrl_t idCtrl;
  logic  loadUse;

  load_use_detect #(.REG_W(REG_W)) uLoadUse (
    .idValid   (bus.IdValid),
    .idUsesRs  (bus.IdUsesRs),
    .idUsesRt  (bus.IdUsesRt),
    .idRs      (bus.IdRs),
    .idRt      (bus.IdRt),
    .exValid   (vld_p1),
    .exMemRead (ctrl_p1.memRead),
    .exRt      (rt_p1),
    .loadUse   (loadUse)
  );

  // Gather ID control into the bundle; an invalid ID slot contributes a bubble.
  always_comb begin
    idCtrl          = CTRL_BUBBLE;
    idCtrl.usesRs   = bus.IdUsesRs;
    idCtrl.usesRt   = bus.IdUsesRt;
    idCtrl.aluOp    = bus.IdALUOp;
    idCtrl.aluSrcA  = bus.IdALUSrcA;
    idCtrl.aluSrcB  = bus.IdALUSrcB;
    idCtrl.regDst   = bus.IdRegDst;
    idCtrl.memToReg = bus.IdMemToReg;
    idCtrl.regWrite = bus.IdRegWrite;
    idCtrl.memRead  = bus.IdMemRead;
    idCtrl.memWrite = bus.IdMemWrite;
    if (!bus.IdValid) idCtrl = CTRL_BUBBLE;
  end

  // Stage boundary ID -> EX: priority is reset, hold, flush, load-use, capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= CTRL_BUBBLE;
      pc_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      shamt_p1  <= '0;
      bubbleCnt <= '0;
    end else if (bus.Hold) begin
      vld_p1    <= vld_p1;
    end else if (bus.Flush || loadUse) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= CTRL_BUBBLE;
      pc_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      shamt_p1  <= '0;
      if (!bus.Flush) bubbleCnt <= satInc(bubbleCnt);
    end else begin
      vld_p1    <= bus.IdValid;
      ctrl_p1   <= idCtrl;
      pc_p1     <= bus.IdPC;
      rd1_p1    <= bus.IdRegData1;
      rd2_p1    <= bus.IdRegData2;
      imm_p1    <= bus.IdExtImm;
      rs_p1     <= bus.IdRs;
      rt_p1     <= bus.IdRt;
      rd_p1     <= bus.IdRd;
      shamt_p1  <= bus.IdShamt;
    end
  end

  // A flushed ID instruction is discarded upstream, so it must not stall.
  assign bus.Stall = !reset && (bus.Hold || (!bus.Flush && loadUse));

  assign bus.ExValid    = vld_p1;
  assign bus.ExPC       = pc_p1;
  assign bus.ExRegData1 = rd1_p1;
  assign bus.ExRegData2 = rd2_p1;
  assign bus.ExExtImm   = imm_p1;
  assign bus.ExRs       = rs_p1;
  assign bus.ExRt       = rt_p1;
  assign bus.ExRd       = rd_p1;
  assign bus.ExShamt    = shamt_p1;
  assign bus.ExUsesRs   = ctrl_p1.usesRs;
  assign bus.ExUsesRt   = ctrl_p1.usesRt;
  assign bus.ExALUOp    = ctrl_p1.aluOp;
  assign bus.ExALUSrcA  = ctrl_p1.aluSrcA;
  assign bus.ExALUSrcB  = ctrl_p1.aluSrcB;
  assign bus.ExRegDst   = ctrl_p1.regDst;
  assign bus.ExMemToReg = ctrl_p1.memToReg;
  assign bus.ExRegWrite = ctrl_p1.regWrite;
  assign bus.ExMemRead  = ctrl_p1.memRead;
  assign bus.ExMemWrite = ctrl_p1.memWrite;
  assign bus.BubbleCnt  = bubbleCnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg. A 4-bit bubble counter keeps saturation reachable.
module tb_id_ex_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  id_ex_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  id_ex_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idClear();
    bus.IdValid = 0; bus.IdPC = 0; bus.IdRegData1 = 0; bus.IdRegData2 = 0;
    bus.IdExtImm = 0; bus.IdRs = 0; bus.IdRt = 0; bus.IdRd = 0; bus.IdShamt = 0;
    bus.IdUsesRs = 0; bus.IdUsesRt = 0; bus.IdALUOp = 0; bus.IdALUSrcA = 0;
    bus.IdALUSrcB = 0; bus.IdRegDst = 0; bus.IdMemToReg = 0; bus.IdRegWrite = 0;
    bus.IdMemRead = 0; bus.IdMemWrite = 0;
  endtask

  // lw rt, imm(rs)
  task automatic idLoad(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] pc);
    idClear();
    bus.IdValid = 1; bus.IdPC = pc; bus.IdRs = rs; bus.IdRt = rt; bus.IdUsesRs = 1;
    bus.IdExtImm = 32'h4; bus.IdALUSrcB = 1; bus.IdMemRead = 1; bus.IdRegWrite = 1;
    bus.IdMemToReg = 2'd1;
  endtask

  // add rd, rs, rt with selectable source usage
  task automatic idAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic usesRs, input logic usesRt, input logic [31:0] pc);
    idClear();
    bus.IdValid = 1; bus.IdPC = pc; bus.IdRs = rs; bus.IdRt = rt; bus.IdRd = rd;
    bus.IdUsesRs = usesRs; bus.IdUsesRt = usesRt; bus.IdRegWrite = 1; bus.IdRegDst = 2'd1;
  endtask

  initial begin
    tests = 0; failed = 0;
    reset = 1; bus.Hold = 0; bus.Flush = 0;
    idClear();
    #1;
    chk("reset_exvalid", 32'(bus.ExValid), 32'd0);
    chk("reset_bubblecnt", 32'(bus.BubbleCnt), 32'd0);
    chk("reset_stall", 32'(bus.Stall), 32'd0);
    tick(); tick();
    reset = 0;

    // Normal capture
    idClear();
    bus.IdValid = 1; bus.IdExtImm = 32'hFFFF8000; bus.IdRegWrite = 1; bus.IdALUOp = 4'd2;
    bus.IdPC = 32'h104; bus.IdRs = 1; bus.IdRt = 2; bus.IdRd = 3; bus.IdRegData1 = 32'h11111111;
    bus.IdRegData2 = 32'h22222222; bus.IdShamt = 5'd7;
    tick();
    chk("cap_extimm", bus.ExExtImm, 32'hFFFF8000);
    chk("cap_regwrite", 32'(bus.ExRegWrite), 32'd1);
    chk("cap_valid", 32'(bus.ExValid), 32'd1);
    chk("cap_aluop", 32'(bus.ExALUOp), 32'd2);
    chk("cap_pc", bus.ExPC, 32'h104);
    chk("cap_rd", 32'(bus.ExRd), 32'd3);
    chk("cap_data1", bus.ExRegData1, 32'h11111111);
    chk("cap_data2", bus.ExRegData2, 32'h22222222);
    chk("cap_shamt", 32'(bus.ExShamt), 32'd7);
    chk("cap_stall", 32'(bus.Stall), 32'd0);

    // Load-use on rs
    idLoad(5'd9, 5'd8, 32'h108);
    tick();
    chk("lw_memread", 32'(bus.ExMemRead), 32'd1);
    chk("lw_rt", 32'(bus.ExRt), 32'd8);
    idAdd(5'd8, 5'd10, 5'd11, 1, 1, 32'h10C);
    #1;
    chk("lu_stall", 32'(bus.Stall), 32'd1);
    tick();
    chk("lu_bub_valid", 32'(bus.ExValid), 32'd0);
    chk("lu_bub_regwrite", 32'(bus.ExRegWrite), 32'd0);
    chk("lu_bub_rs", 32'(bus.ExRs), 32'd0);
    chk("lu_bub_pc", bus.ExPC, 32'd0);
    chk("lu_cnt1", 32'(bus.BubbleCnt), 32'd1);
    chk("lu_stall_drop", 32'(bus.Stall), 32'd0);
    tick();
    chk("lu_adv_rs", 32'(bus.ExRs), 32'd8);
    chk("lu_adv_rd", 32'(bus.ExRd), 32'd11);
    chk("lu_adv_valid", 32'(bus.ExValid), 32'd1);
    chk("lu_adv_cnt", 32'(bus.BubbleCnt), 32'd1);

    // No false hazard: load into r0
    idLoad(5'd9, 5'd0, 32'h110);
    tick();
    idAdd(5'd0, 5'd0, 5'd5, 1, 1, 32'h114);
    #1;
    chk("nf_rt0_stall", 32'(bus.Stall), 32'd0);
    tick();
    chk("nf_rt0_rd", 32'(bus.ExRd), 32'd5);

    // No false hazard: matching rs but not read
    idLoad(5'd9, 5'd8, 32'h118);
    tick();
    idAdd(5'd8, 5'd3, 5'd6, 0, 1, 32'h11C);
    #1;
    chk("nf_unused_stall", 32'(bus.Stall), 32'd0);
    tick();
    chk("nf_unused_rd", 32'(bus.ExRd), 32'd6);
    chk("nf_cnt", 32'(bus.BubbleCnt), 32'd1);

    // Flush beats load-use (hazard via rt)
    idLoad(5'd9, 5'd8, 32'h120);
    tick();
    idAdd(5'd4, 5'd8, 5'd7, 1, 1, 32'h124);
    #1;
    chk("fl_pre_stall", 32'(bus.Stall), 32'd1);
    bus.Flush = 1;
    #1;
    chk("fl_stall", 32'(bus.Stall), 32'd0);
    tick();
    bus.Flush = 0;
    chk("fl_valid", 32'(bus.ExValid), 32'd0);
    chk("fl_memread", 32'(bus.ExMemRead), 32'd0);
    chk("fl_rt", 32'(bus.ExRt), 32'd0);
    chk("fl_cnt", 32'(bus.BubbleCnt), 32'd1);

    // Hold for three cycles, Flush raised during the last one
    idAdd(5'd1, 5'd2, 5'd20, 1, 1, 32'h200);
    tick();
    bus.Hold = 1;
    for (int i = 0; i < 3; i++) begin
      idAdd(5'd3, 5'd4, 5'(21 + i), 1, 1, 32'h204 + 32'(4 * i));
      if (i == 2) bus.Flush = 1;
      #1;
      chk("hold_stall", 32'(bus.Stall), 32'd1);
      tick();
      chk("hold_pc", bus.ExPC, 32'h200);
      chk("hold_rd", 32'(bus.ExRd), 32'd20);
      chk("hold_valid", 32'(bus.ExValid), 32'd1);
    end
    bus.Hold = 0; bus.Flush = 0;
    idAdd(5'd3, 5'd4, 5'd25, 1, 1, 32'h214);
    tick();
    chk("hold_resume_rd", 32'(bus.ExRd), 32'd25);
    chk("hold_resume_pc", bus.ExPC, 32'h214);

    // IdValid=0: data captured, control forced off
    idClear();
    bus.IdPC = 32'h300; bus.IdRegWrite = 1; bus.IdMemWrite = 1; bus.IdALUOp = 4'd3;
    tick();
    chk("inv_pc", bus.ExPC, 32'h300);
    chk("inv_regwrite", 32'(bus.ExRegWrite), 32'd0);
    chk("inv_memwrite", 32'(bus.ExMemWrite), 32'd0);
    chk("inv_aluop", 32'(bus.ExALUOp), 32'd0);
    chk("inv_valid", 32'(bus.ExValid), 32'd0);

    // Asynchronous reset in the middle of a stall
    idLoad(5'd9, 5'd8, 32'h400);
    tick();
    idAdd(5'd8, 5'd10, 5'd12, 1, 1, 32'h404);
    #1;
    chk("rst_pre_stall", 32'(bus.Stall), 32'd1);
    #1;
    reset = 1;
    #1;
    chk("rst_valid", 32'(bus.ExValid), 32'd0);
    chk("rst_memread", 32'(bus.ExMemRead), 32'd0);
    chk("rst_pc", bus.ExPC, 32'd0);
    chk("rst_cnt", 32'(bus.BubbleCnt), 32'd0);
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    #1;
    reset = 0;
    tick();
    chk("rst_after_rd", 32'(bus.ExRd), 32'd12);
    chk("rst_after_valid", 32'(bus.ExValid), 32'd1);

    // Saturation: each lw re-presented against itself yields one bubble per two edges
    idLoad(5'd8, 5'd8, 32'h500);
    for (int i = 0; i < 28; i++) tick();
    chk("sat_cnt14", 32'(bus.BubbleCnt), 32'd14);
    tick(); tick();
    chk("sat_cnt15", 32'(bus.BubbleCnt), 32'd15);
    tick();
    chk("sat_stall", 32'(bus.Stall), 32'd1);
    tick();
    chk("sat_hold15", 32'(bus.BubbleCnt), 32'd15);
    chk("sat_bub_valid", 32'(bus.ExValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
